// File: rtl/psg_env_ctrl_if.sv
// Host, envelope-config and PSG attribute-write signals of psg_env_ctrl.
interface psg_env_ctrl_if;
    logic [5:0] host_addr;
    logic [7:0] host_wrdata;
    logic       host_write;
    logic [4:0] env_addr;
    logic [7:0] env_wrdata;
    logic       env_write;
    logic       tick;
    logic [5:0] attr_addr;
    logic [7:0] attr_wrdata;
    logic       attr_write;
    logic       busy;
    logic       overrun;

    modport master (
        output host_addr, host_wrdata, host_write,
        output env_addr, env_wrdata, env_write, tick,
        input  attr_addr, attr_wrdata, attr_write, busy, overrun
    );

    modport slave (
        input  host_addr, host_wrdata, host_write,
        input  env_addr, env_wrdata, env_write, tick,
        output attr_addr, attr_wrdata, attr_write, busy, overrun
    );
endinterface

// File: rtl/psg_env_ctrl.sv
// PSG attribute-write arbiter: host pass-through plus a per-channel volume
// envelope engine that scans all 16 channels once per sample tick.
module psg_env_ctrl #(
    parameter int unsigned RATE_W = 8
) (
    input logic clk,
    input logic rst,
    psg_env_ctrl_if.slave bus
);
    typedef enum logic {IDLE, SCAN} state_t;

    state_t            state_q, state_d;
    logic [3:0]        ch_q, ch_d;
    logic              tick_pending_q, tick_pending_d;
    logic              overrun_q, overrun_d;
    logic [5:0]        attr_addr_q, attr_addr_d;
    logic [7:0]        attr_wrdata_q, attr_wrdata_d;
    logic              attr_write_q, attr_write_d;
    logic [7:0]        shadow_q [16];
    logic [7:0]        shadow_d [16];
    logic [5:0]        target_q [16];
    logic [5:0]        target_d [16];
    logic [RATE_W-1:0] rate_q [16];
    logic [RATE_W-1:0] rate_d [16];
    logic [RATE_W-1:0] cnt_q [16];
    logic [RATE_W-1:0] cnt_d [16];

    logic [3:0]        env_ch, host_ch;
    logic              env_sel;
    logic [5:0]        eff_target, vol;
    logic [RATE_W-1:0] eff_rate, eff_cnt;
    logic [7:0]        new_shadow;

    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        tick_pending_d = tick_pending_q;
        overrun_d      = 1'b0;
        attr_addr_d    = attr_addr_q;
        attr_wrdata_d  = attr_wrdata_q;
        attr_write_d   = 1'b0;
        shadow_d       = shadow_q;
        target_d       = target_q;
        rate_d         = rate_q;
        cnt_d          = cnt_q;

        env_ch  = bus.env_addr[4:1];
        env_sel = bus.env_addr[0];
        host_ch = bus.host_addr[5:2];

        // A config write to the channel under scan is bypassed into this
        // cycle's evaluation so the scan and the config never disagree.
        eff_target = target_q[ch_q];
        eff_rate   = rate_q[ch_q];
        eff_cnt    = cnt_q[ch_q];
        if (bus.env_write && env_ch == ch_q) begin
            if (!env_sel) begin
                eff_target = bus.env_wrdata[5:0];
            end else begin
                eff_rate = bus.env_wrdata[RATE_W-1:0];
                eff_cnt  = '0;
            end
        end
        vol        = shadow_q[ch_q][5:0];
        new_shadow = shadow_q[ch_q];

        if (bus.env_write) begin
            if (!env_sel) begin
                target_d[env_ch] = bus.env_wrdata[5:0];
            end else begin
                rate_d[env_ch] = bus.env_wrdata[RATE_W-1:0];
                cnt_d[env_ch]  = '0;
            end
        end

        if (bus.host_write) begin
            attr_addr_d   = bus.host_addr;
            attr_wrdata_d = bus.host_wrdata;
            attr_write_d  = 1'b1;
            if (bus.host_addr[1:0] == 2'd2) shadow_d[host_ch] = bus.host_wrdata;
        end

        if (state_q == IDLE) begin
            if (bus.tick || tick_pending_q) begin
                state_d        = SCAN;
                ch_d           = '0;
                tick_pending_d = 1'b0;
            end
        end else begin
            if (bus.tick) begin
                if (tick_pending_q) overrun_d = 1'b1;
                else                tick_pending_d = 1'b1;
            end
            if (!bus.host_write) begin
                if (eff_rate == '0) begin
                    cnt_d[ch_q] = '0;
                end else if (eff_cnt != '0) begin
                    cnt_d[ch_q] = eff_cnt - RATE_W'(1);
                end else begin
                    cnt_d[ch_q] = eff_rate - RATE_W'(1);
                    if (vol != eff_target) begin
                        new_shadow[5:0] = (vol < eff_target) ? vol + 6'd1 : vol - 6'd1;
                        shadow_d[ch_q]  = new_shadow;
                        attr_addr_d     = {ch_q, 2'b10};
                        attr_wrdata_d   = new_shadow;
                        attr_write_d    = 1'b1;
                    end
                end
                if (ch_q == 4'd15) state_d = IDLE;
                else               ch_d = ch_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            ch_q           <= '0;
            tick_pending_q <= 1'b0;
            overrun_q      <= 1'b0;
            attr_addr_q    <= '0;
            attr_wrdata_q  <= '0;
            attr_write_q   <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) begin
                shadow_q[i] <= '0;
                target_q[i] <= '0;
                rate_q[i]   <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            tick_pending_q <= tick_pending_d;
            overrun_q      <= overrun_d;
            attr_addr_q    <= attr_addr_d;
            attr_wrdata_q  <= attr_wrdata_d;
            attr_write_q   <= attr_write_d;
            shadow_q       <= shadow_d;
            target_q       <= target_d;
            rate_q         <= rate_d;
            cnt_q          <= cnt_d;
        end
    end

    assign bus.attr_addr   = attr_addr_q;
    assign bus.attr_wrdata = attr_wrdata_q;
    assign bus.attr_write  = attr_write_q;
    assign bus.busy        = (state_q == SCAN);
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_psg_env_ctrl.sv
// Scoreboard bench for psg_env_ctrl: expected attribute writes are queued as
// stimulus is driven and popped by a monitor as the DUT emits them.
module tb_psg_env_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   ov_cnt;
    logic [13:0] exp_q [$];

    psg_env_ctrl_if bus ();

    psg_env_ctrl #(.RATE_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic monitor();
        logic [13:0] e;
        forever begin
            @(negedge clk);
            if (bus.overrun === 1'b1) ov_cnt++;
            if (bus.attr_write === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                             bus.attr_addr, bus.attr_wrdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.attr_addr, bus.attr_wrdata} !== e) begin
                        errors++;
                        $display("FAIL attr_write: got addr=%h data=%h, required addr=%h data=%h",
                                 bus.attr_addr, bus.attr_wrdata, e[13:8], e[7:0]);
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [5:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
        bus.host_addr   = a;
        bus.host_wrdata = d;
        bus.host_write  = 1'b1;
        step();
        bus.host_write  = 1'b0;
    endtask

    task automatic env_wr(input logic [3:0] ch, input logic sel, input logic [7:0] d);
        bus.env_addr   = {ch, sel};
        bus.env_wrdata = d;
        bus.env_write  = 1'b1;
        step();
        bus.env_write  = 1'b0;
    endtask

    task automatic do_tick();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            step();
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy still high after %0d cycles, required low", n);
        end
    endtask

    task automatic check_drained(input string name);
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: got %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        checks += 5;
        if (bus.attr_write !== 1'b0) begin errors++; $display("FAIL reset_attr_write: got %b required 0", bus.attr_write); end
        if (bus.attr_addr !== 6'h00) begin errors++; $display("FAIL reset_attr_addr: got %h required 00", bus.attr_addr); end
        if (bus.attr_wrdata !== 8'h00) begin errors++; $display("FAIL reset_attr_wrdata: got %h required 00", bus.attr_wrdata); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
        if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b required 0", bus.overrun); end
    endtask

    task automatic test_host_pass();
        host_wr(6'h06, 8'hC0);
        checks += 2;
        if (bus.attr_write !== 1'b1 || bus.attr_addr !== 6'h06 || bus.attr_wrdata !== 8'hC0) begin
            errors++;
            $display("FAIL host_latency: got we=%b addr=%h data=%h, required we=1 addr=06 data=c0",
                     bus.attr_write, bus.attr_addr, bus.attr_wrdata);
        end
        step();
        if (bus.attr_write !== 1'b0) begin
            errors++;
            $display("FAIL host_single: got we=%b, required 0", bus.attr_write);
        end
        check_drained("host_pass");
    endtask

    task automatic test_fade_rate1();
        int n;
        host_wr(6'h02, 8'hC0);
        env_wr(4'd0, 1'b0, 8'd3);
        env_wr(4'd0, 1'b1, 8'd1);
        for (int t = 0; t < 4; t++) begin
            if (t < 3) exp_q.push_back({6'h02, 8'hC1 + 8'(t)});
            do_tick();
            wait_idle(n);
            if (t == 0) begin
                checks++;
                if (n !== 16) begin errors++; $display("FAIL scan_length: got %0d cycles, required 16", n); end
            end
        end
        check_drained("fade_rate1");
    endtask

    task automatic test_fade_rate3();
        int n;
        host_wr(6'h16, 8'h0A);
        env_wr(4'd5, 1'b0, 8'd8);
        env_wr(4'd5, 1'b1, 8'd3);
        for (int t = 0; t < 9; t++) begin
            if (t == 0) exp_q.push_back({6'h16, 8'h09});
            if (t == 3) exp_q.push_back({6'h16, 8'h08});
            do_tick();
            wait_idle(n);
        end
        check_drained("fade_rate3");
    endtask

    task automatic test_saturate();
        int n;
        host_wr(6'h12, 8'hFE);
        env_wr(4'd4, 1'b0, 8'd63);
        env_wr(4'd4, 1'b1, 8'd1);
        host_wr(6'h1A, 8'h01);
        env_wr(4'd6, 1'b0, 8'd0);
        env_wr(4'd6, 1'b1, 8'd1);
        exp_q.push_back({6'h12, 8'hFF});
        exp_q.push_back({6'h1A, 8'h00});
        for (int t = 0; t < 3; t++) begin
            do_tick();
            wait_idle(n);
        end
        check_drained("saturate");
    endtask

    task automatic test_stall();
        int n;
        host_wr(6'h0A, 8'h40);
        env_wr(4'd2, 1'b0, 8'd1);
        env_wr(4'd2, 1'b1, 8'd1);
        do_tick();
        fork
            begin
                step();
                step();
                host_wr(6'h24, 8'h11);
                host_wr(6'h24, 8'h22);
                host_wr(6'h24, 8'h33);
                exp_q.push_back({6'h0A, 8'h41});
            end
            wait_idle(n);
        join
        checks++;
        if (n !== 19) begin errors++; $display("FAIL stall_busy: got %0d cycles, required 19", n); end
        check_drained("stall");
    endtask

    task automatic test_back_to_back();
        int n;
        int ov0;
        ov0 = ov_cnt;
        bus.tick = 1'b1;
        step();
        step();
        step();
        bus.tick = 1'b0;
        checks++;
        if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_pulse: got %b required 1", bus.overrun); end
        wait_idle(n);
        checks++;
        if (n !== 14) begin errors++; $display("FAIL first_scan_rest: got %0d cycles, required 14", n); end
        step();
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL pending_scan_start: got busy=%b required 1", bus.busy); end
        wait_idle(n);
        checks += 2;
        if (n !== 16) begin errors++; $display("FAIL second_scan: got %0d cycles, required 16", n); end
        if (ov_cnt - ov0 !== 1) begin errors++; $display("FAIL overrun_count: got %0d pulses, required 1", ov_cnt - ov0); end
        check_drained("back_to_back");
    endtask

    task automatic test_reset_mid_scan();
        int n;
        host_wr(6'h0E, 8'h80);
        env_wr(4'd3, 1'b0, 8'd5);
        env_wr(4'd3, 1'b1, 8'd1);
        do_tick();
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        checks += 2;
        if (bus.attr_write !== 1'b0) begin errors++; $display("FAIL rst_attr_write: got %b required 0", bus.attr_write); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
        step();
        step();
        rst = 1'b0;
        step();
        do_tick();
        wait_idle(n);
        checks++;
        if (n !== 16) begin errors++; $display("FAIL post_rst_scan: got %0d cycles, required 16", n); end
        check_drained("reset_mid_scan");
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        ov_cnt          = 0;
        rst             = 1'b1;
        bus.host_addr   = '0;
        bus.host_wrdata = '0;
        bus.host_write  = 1'b0;
        bus.env_addr    = '0;
        bus.env_wrdata  = '0;
        bus.env_write   = 1'b0;
        bus.tick        = 1'b0;
        fork
            monitor();
        join_none
        step();
        step();
        test_reset();
        rst = 1'b0;
        step();
        test_host_pass();
        test_fade_rate1();
        test_fade_rate3();
        test_saturate();
        test_stall();
        test_back_to_back();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
